// File: rtl/noc_local_port_if_if.sv
// Local-port signal bundle between core/DMA logic and the NoC interface.
// slave: the port block itself; master: the core side driving it.
interface noc_local_port_if_if #(
    parameter int FLIT_W = 32,
    parameter int NUM_VC = 2
);
    logic [NUM_VC-1:0]        inj_valid;
    logic [NUM_VC*FLIT_W-1:0] inj_data;
    logic [NUM_VC-1:0]        inj_ready;
    logic [FLIT_W-1:0]        noc_flit_out;
    logic [NUM_VC-1:0]        noc_vc_wr_out;
    logic [NUM_VC-1:0]        noc_cred_in;
    logic [FLIT_W-1:0]        noc_flit_in;
    logic [NUM_VC-1:0]        noc_vc_wr_in;
    logic [NUM_VC-1:0]        noc_cred_out;
    logic [NUM_VC-1:0]        ej_valid;
    logic [NUM_VC*FLIT_W-1:0] ej_data;
    logic [NUM_VC-1:0]        ej_ready;
    logic                     err_cred_ovf;
    logic                     err_rx;

    modport slave (
        input  inj_valid, inj_data, noc_cred_in,
        input  noc_flit_in, noc_vc_wr_in, ej_ready,
        output inj_ready, noc_flit_out, noc_vc_wr_out,
        output noc_cred_out, ej_valid, ej_data,
        output err_cred_ovf, err_rx
    );

    modport master (
        output inj_valid, inj_data, noc_cred_in,
        output noc_flit_in, noc_vc_wr_in, ej_ready,
        input  inj_ready, noc_flit_out, noc_vc_wr_out,
        input  noc_cred_out, ej_valid, ej_data,
        input  err_cred_ovf, err_rx
    );
endinterface

// File: rtl/noc_local_port_if.sv
// NoC local-port network interface: credit-based round-robin injection
// over NUM_VC virtual channels and per-VC fall-through ejection FIFOs.
module noc_local_port_if #(
    parameter int FLIT_W   = 32,
    parameter int NUM_VC   = 2,
    parameter int TX_CRED  = 4,
    parameter int RX_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    noc_local_port_if_if.slave bus
);
    localparam int CW = $clog2(TX_CRED + 1);
    localparam int PW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int NW = $clog2(RX_DEPTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(TX_CRED);
    localparam logic [NW-1:0] FULL = NW'(RX_DEPTH);
    localparam logic [AW-1:0] ALST = AW'(RX_DEPTH - 1);
    localparam logic [PW-1:0] VLST = PW'(NUM_VC - 1);

    logic [CW-1:0]     cred [NUM_VC];
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [NUM_VC-1:0] elig;
    logic [NUM_VC-1:0] gnt;
    logic              found;
    logic [FLIT_W-1:0] sel_flit;
    logic [FLIT_W-1:0] flit_q;
    logic [NUM_VC-1:0] vcwr_q;
    logic              ovf_q;

    logic [FLIT_W-1:0] mem [NUM_VC][RX_DEPTH];
    logic [AW-1:0]     rd_ptr [NUM_VC];
    logic [AW-1:0]     wr_ptr [NUM_VC];
    logic [NW-1:0]     cnt [NUM_VC];
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] drop;
    logic              wr_bad;
    logic [NUM_VC-1:0] cred_q;
    logic              rx_err_q;
    logic [NUM_VC-1:0] ej_valid_c;
    logic [NUM_VC*FLIT_W-1:0] ej_data_c;

    // Round-robin pick among VCs with a pending flit and a nonzero credit.
    always_comb begin
        int s;
        s        = 0;
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        sel_flit = '0;
        for (int v = 0; v < NUM_VC; v++)
            elig[v] = bus.inj_valid[v] && (cred[v] != '0);
        for (int i = 0; i < NUM_VC; i++) begin
            s = int'(rr_ptr) + i;
            if (s >= NUM_VC) s = s - NUM_VC;
            if (!found && elig[PW'(s)]) begin
                found        = 1'b1;
                gnt[PW'(s)]  = 1'b1;
                gnt_idx      = PW'(s);
            end
        end
        for (int v = 0; v < NUM_VC; v++)
            if (gnt[v]) sel_flit = bus.inj_data[v*FLIT_W +: FLIT_W];
    end

    // Credit counters, RR pointer and the overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) cred[v] <= CMAX;
            rr_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (found)
                rr_ptr <= (gnt_idx == VLST) ? '0 : gnt_idx + 1'b1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (bus.noc_cred_in[v] && !gnt[v]) begin
                    if (cred[v] == CMAX) ovf_q <= 1'b1;
                    else cred[v] <= cred[v] + 1'b1;
                end else if (gnt[v] && !bus.noc_cred_in[v]) begin
                    cred[v] <= cred[v] - 1'b1;
                end
            end
        end
    end

    // Registered launch; the flit bus keeps its last value while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_q <= '0;
            vcwr_q <= '0;
        end else begin
            vcwr_q <= gnt;
            if (found) flit_q <= sel_flit;
        end
    end

    // Receive-side push/pop qualification and error detection.
    always_comb begin
        wr_bad = !$onehot0(bus.noc_vc_wr_in);
        for (int v = 0; v < NUM_VC; v++) begin
            pop[v]  = bus.ej_ready[v] && (cnt[v] != '0);
            push[v] = $onehot(bus.noc_vc_wr_in) && bus.noc_vc_wr_in[v]
                      && ((cnt[v] != FULL) || pop[v]);
            drop[v] = $onehot(bus.noc_vc_wr_in) && bus.noc_vc_wr_in[v]
                      && (cnt[v] == FULL) && !pop[v];
        end
    end

    // Per-VC receive FIFOs, credit-return pulses and the rx error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                cnt[v]    <= '0;
                for (int d = 0; d < RX_DEPTH; d++) mem[v][d] <= '0;
            end
            cred_q   <= '0;
            rx_err_q <= 1'b0;
        end else begin
            cred_q <= pop;
            if (wr_bad || (drop != '0)) rx_err_q <= 1'b1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) begin
                    mem[v][wr_ptr[v]] <= bus.noc_flit_in;
                    wr_ptr[v] <= (wr_ptr[v] == ALST) ? '0 : wr_ptr[v] + 1'b1;
                end
                if (pop[v])
                    rd_ptr[v] <= (rd_ptr[v] == ALST) ? '0 : rd_ptr[v] + 1'b1;
                if (push[v] && !pop[v]) cnt[v] <= cnt[v] + 1'b1;
                else if (pop[v] && !push[v]) cnt[v] <= cnt[v] - 1'b1;
            end
        end
    end

    // Fall-through head of every FIFO.
    always_comb begin
        ej_valid_c = '0;
        ej_data_c  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            ej_valid_c[v] = (cnt[v] != '0);
            ej_data_c[v*FLIT_W +: FLIT_W] = mem[v][rd_ptr[v]];
        end
    end

    assign bus.inj_ready     = rst ? gnt : '0;
    assign bus.noc_flit_out  = flit_q;
    assign bus.noc_vc_wr_out = vcwr_q;
    assign bus.noc_cred_out  = cred_q;
    assign bus.ej_valid      = ej_valid_c;
    assign bus.ej_data       = ej_data_c;
    assign bus.err_cred_ovf  = ovf_q;
    assign bus.err_rx        = rx_err_q;
endmodule

// File: tb/tb_noc_local_port_if.sv
// Directed bench for noc_local_port_if: reference model of credits, RR
// and receive FIFOs, with a launch scoreboard queue checked a cycle later.
module tb_noc_local_port_if;
    localparam int FW = 32;
    localparam int NV = 2;
    localparam int TC = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    noc_local_port_if_if #(.FLIT_W(FW), .NUM_VC(NV)) bus ();

    noc_local_port_if #(
        .FLIT_W(FW), .NUM_VC(NV), .TX_CRED(TC), .RX_DEPTH(RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_gnt  = 0;

    logic [NV+FW-1:0] sb_q [$];
    int               m_cred [NV];
    int               m_ptr;
    bit               m_ovf;
    bit               m_err;
    logic [FW-1:0]    m_fifo [NV][RD];
    int               m_cnt [NV];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_cred[v] = TC;
            m_cnt[v]  = 0;
        end
        m_ptr = 0;
        m_ovf = 0;
        m_err = 0;
        sb_q.delete();
    endtask

    task automatic step();
        logic [NV-1:0]    eg;
        logic [NV-1:0]    pp;
        logic [NV+FW-1:0] e;
        bit               got;
        int               idx;
        int               gi;
        gi  = 0;
        eg  = '0;
        pp  = '0;
        got = 0;
        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            idx = (m_ptr + i) % NV;
            if (!got && bus.inj_valid[idx] && m_cred[idx] != 0) begin
                got = 1;
                eg[idx] = 1'b1;
                gi = idx;
            end
        end
        chk("inj_ready", 64'(bus.inj_ready), 64'(eg));
        n_gnt += $countones(bus.inj_ready);
        for (int v = 0; v < NV; v++) begin
            chk("ej_valid", 64'(bus.ej_valid[v]), 64'(m_cnt[v] != 0));
            if (m_cnt[v] != 0)
                chk("ej_data", 64'(bus.ej_data[v*FW +: FW]),
                    64'(m_fifo[v][0]));
        end
        if (got) begin
            sb_q.push_back({eg, bus.inj_data[gi*FW +: FW]});
            m_ptr = (gi + 1) % NV;
        end
        for (int v = 0; v < NV; v++) begin
            if (bus.noc_cred_in[v] && !eg[v]) begin
                if (m_cred[v] == TC) m_ovf = 1;
                else m_cred[v]++;
            end else if (eg[v] && !bus.noc_cred_in[v]) begin
                m_cred[v]--;
            end
        end
        for (int v = 0; v < NV; v++) begin
            if (bus.ej_ready[v] && m_cnt[v] != 0) begin
                pp[v] = 1'b1;
                for (int d = 0; d < RD - 1; d++)
                    m_fifo[v][d] = m_fifo[v][d+1];
                m_cnt[v]--;
            end
        end
        if (!$onehot0(bus.noc_vc_wr_in)) m_err = 1;
        if ($onehot(bus.noc_vc_wr_in)) begin
            for (int v = 0; v < NV; v++) begin
                if (bus.noc_vc_wr_in[v]) begin
                    if (m_cnt[v] < RD) begin
                        m_fifo[v][m_cnt[v]] = bus.noc_flit_in;
                        m_cnt[v]++;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("vc_wr_out", 64'(bus.noc_vc_wr_out), 64'(e[NV+FW-1:FW]));
            chk("flit_out", 64'(bus.noc_flit_out), 64'(e[FW-1:0]));
        end else begin
            chk("vc_wr_idle", 64'(bus.noc_vc_wr_out), 64'(0));
        end
        chk("cred_out", 64'(bus.noc_cred_out), 64'(pp));
        chk("err_cred_ovf", 64'(bus.err_cred_ovf), 64'(m_ovf));
        chk("err_rx", 64'(bus.err_rx), 64'(m_err));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_inj_ready", 64'(bus.inj_ready), 64'(0));
        chk("rst_vc_wr_out", 64'(bus.noc_vc_wr_out), 64'(0));
        chk("rst_flit_out", 64'(bus.noc_flit_out), 64'(0));
        chk("rst_cred_out", 64'(bus.noc_cred_out), 64'(0));
        chk("rst_ej_valid", 64'(bus.ej_valid), 64'(0));
        chk("rst_ej_data", 64'(bus.ej_data), 64'(0));
        chk("rst_err_ovf", 64'(bus.err_cred_ovf), 64'(0));
        chk("rst_err_rx", 64'(bus.err_rx), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.inj_valid    = '0;
        bus.inj_data     = '0;
        bus.noc_cred_in  = '0;
        bus.noc_flit_in  = '0;
        bus.noc_vc_wr_in = '0;
        bus.ej_ready     = '0;
        do_reset();

        bus.inj_valid = 2'b01;
        n_gnt = 0;
        for (int i = 0; i < 6; i++) begin
            bus.inj_data = {FW'(32'h200 + i), FW'(32'h100 + i)};
            step();
        end
        chk("t1_grants", 64'(n_gnt), 64'(4));
        bus.noc_cred_in = 2'b01;
        n_gnt = 0;
        step();
        bus.noc_cred_in = 2'b00;
        for (int i = 0; i < 3; i++) step();
        chk("t1_extra", 64'(n_gnt), 64'(1));

        do_reset();
        bus.inj_valid = 2'b11;
        n_gnt = 0;
        for (int i = 0; i < 10; i++) begin
            bus.inj_data = {FW'(32'h1100 + i), FW'(32'h1000 + i)};
            step();
        end
        chk("t2_grants", 64'(n_gnt), 64'(8));

        bus.inj_valid   = 2'b00;
        bus.noc_cred_in = 2'b10;
        step();
        step();
        bus.inj_valid = 2'b10;
        bus.inj_data  = {FW'(32'h5A5A_0001), FW'(0)};
        step();
        bus.noc_cred_in = 2'b00;
        n_gnt = 0;
        for (int i = 0; i < 3; i++) step();
        chk("t3_cred1", 64'(n_gnt), 64'(2));
        bus.inj_valid   = 2'b00;
        bus.noc_cred_in = 2'b01;
        for (int i = 0; i < 4; i++) step();
        chk("t3_no_ovf", 64'(bus.err_cred_ovf), 64'(0));
        step();
        bus.noc_cred_in = 2'b00;
        chk("t3_ovf", 64'(bus.err_cred_ovf), 64'(1));

        bus.noc_vc_wr_in = 2'b10;
        for (int i = 0; i < 5; i++) begin
            bus.noc_flit_in = FW'(32'hA0 + i);
            step();
        end
        bus.noc_vc_wr_in = 2'b00;
        chk("t4_err_rx", 64'(bus.err_rx), 64'(1));
        chk("t4_ej_valid", 64'(bus.ej_valid), 64'(2'b10));
        chk("t4_head0", 64'(bus.ej_data[FW +: FW]), 64'(32'hA0));
        bus.ej_ready = 2'b10;
        step();
        bus.ej_ready = 2'b00;
        chk("t4_cred_out", 64'(bus.noc_cred_out), 64'(2'b10));
        chk("t4_head1", 64'(bus.ej_data[FW +: FW]), 64'(32'hA1));
        step();

        do_reset();
        bus.noc_vc_wr_in = 2'b11;
        bus.noc_flit_in  = FW'(32'hDEAD);
        step();
        bus.noc_vc_wr_in = 2'b00;
        chk("t5_err_rx", 64'(bus.err_rx), 64'(1));
        chk("t5_no_push", 64'(bus.ej_valid), 64'(0));
        do_reset();
        bus.noc_vc_wr_in = 2'b10;
        for (int i = 0; i < 4; i++) begin
            bus.noc_flit_in = FW'(32'hB0 + i);
            step();
        end
        bus.noc_vc_wr_in = 2'b01;
        bus.noc_flit_in  = FW'(32'hC0);
        step();
        bus.noc_vc_wr_in = 2'b10;
        bus.noc_flit_in  = FW'(32'hB4);
        bus.ej_ready     = 2'b10;
        step();
        bus.noc_vc_wr_in = 2'b00;
        chk("t5_pushpop_err", 64'(bus.err_rx), 64'(0));
        chk("t5_head", 64'(bus.ej_data[FW +: FW]), 64'(32'hB1));
        bus.ej_ready = 2'b11;
        step();
        chk("t5_dual_cred", 64'(bus.noc_cred_out), 64'(2'b11));
        bus.ej_ready = 2'b10;
        for (int i = 0; i < 4; i++) step();
        bus.ej_ready = 2'b00;
        step();
        chk("t5_drained", 64'(bus.ej_valid), 64'(0));

        do_reset();
        bus.inj_valid    = 2'b01;
        bus.noc_vc_wr_in = 2'b10;
        for (int i = 0; i < 3; i++) begin
            bus.inj_data    = {FW'(0), FW'(32'h7700 + i)};
            bus.noc_flit_in = FW'(32'hE0 + i);
            if (i == 2) bus.noc_vc_wr_in = 2'b00;
            step();
        end
        chk("t6_pre_valid", 64'(bus.ej_valid), 64'(2'b10));
        do_reset();
        bus.inj_valid = 2'b11;
        bus.inj_data  = {FW'(32'h8801), FW'(32'h8800)};
        n_gnt = 0;
        step();
        bus.inj_valid = 2'b01;
        for (int i = 0; i < 5; i++) step();
        chk("t6_cred", 64'(n_gnt), 64'(4));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
